// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg
// Shared widths and helper types for the register file / PC slice.
//   REG_W    : data width of one architectural register
//   NREG     : number of architectural registers
//   RADDR_W  : register address width
//   SB_CNT_W : width of each per-register pending-write counter
// ---------------------------------------------------------------------------
package cpu_pkg;

    localparam int REG_W    = 16;
    localparam int NREG     = 8;
    localparam int RADDR_W  = 3;
    localparam int SB_CNT_W = 2;

    typedef logic [REG_W-1:0]    word_t;
    typedef logic [RADDR_W-1:0]  raddr_t;
    typedef logic [SB_CNT_W-1:0] sb_cnt_t;

    // Largest value a pending counter can hold before further issues overflow
    localparam sb_cnt_t SB_CNT_MAX = '1;

    // Upper byte from the incoming value, lower byte kept from the old value
    function automatic word_t merge_high(word_t new_val, word_t old_val);
        return {new_val[REG_W-1:REG_W/2], old_val[REG_W/2-1:0]};
    endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// ---------------------------------------------------------------------------
// rf_scoreboard
// Tracks how many writes are still in flight for each register.
//   clk, reset           : clock, synchronous active-high reset
//   issue_valid/addr     : decode issued an instruction that will write addr
//   retire_valid/addr    : writeback is writing addr this cycle
//   squash               : redirect; all pending counts drop to zero
//   rd_addr_a/b          : registers being looked up
//   rd_busy_a/b          : looked-up register still has a pending write
//   sb_error             : sticky flag, an issue overflowed a full counter
// ---------------------------------------------------------------------------
module rf_scoreboard
    import cpu_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               issue_valid,
    input  logic [RADDR_W-1:0] issue_addr,
    input  logic               retire_valid,
    input  logic [RADDR_W-1:0] retire_addr,
    input  logic               squash,
    input  logic [RADDR_W-1:0] rd_addr_a,
    input  logic [RADDR_W-1:0] rd_addr_b,
    output logic               rd_busy_a,
    output logic               rd_busy_b,
    output logic               sb_error
);

    sb_cnt_t         cnt      [NREG];
    sb_cnt_t         cnt_next [NREG];
    logic [NREG-1:0] inc_vec;
    logic [NREG-1:0] dec_vec;
    logic            err_next;

    // One-hot decode of the issuing and retiring destinations
    always_comb begin
        inc_vec = '0;
        dec_vec = '0;
        for (int i = 0; i < NREG; i++) begin
            inc_vec[i] = issue_valid && (int'(issue_addr) == i);
            dec_vec[i] = retire_valid && (int'(retire_addr) == i);
        end
    end

    // Counter update: a squash wins over everything and also discards the
    // issue in the same cycle, so it can never raise the error flag.
    // An issue and a retire to the same register cancel out. Retiring an
    // idle register is tolerated (forced writes such as a call link).
    always_comb begin
        err_next = sb_error;
        for (int i = 0; i < NREG; i++) begin
            cnt_next[i] = cnt[i];
            if (squash) begin
                cnt_next[i] = '0;
            end else begin
                case ({inc_vec[i], dec_vec[i]})
                    2'b10: begin
                        if (cnt[i] == SB_CNT_MAX) begin
                            err_next = 1'b1;
                        end else begin
                            cnt_next[i] = cnt[i] + sb_cnt_t'(1);
                        end
                    end
                    2'b01: begin
                        if (cnt[i] != '0) begin
                            cnt_next[i] = cnt[i] - sb_cnt_t'(1);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Counter and error state
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) begin
                cnt[i] <= '0;
            end
            sb_error <= 1'b0;
        end else begin
            for (int i = 0; i < NREG; i++) begin
                cnt[i] <= cnt_next[i];
            end
            sb_error <= err_next;
        end
    end

    // A write retiring this cycle no longer counts as pending for readers
    assign rd_busy_a = cnt[rd_addr_a] > sb_cnt_t'(dec_vec[rd_addr_a]);
    assign rd_busy_b = cnt[rd_addr_b] > sb_cnt_t'(dec_vec[rd_addr_b]);

endmodule

// File: rtl/regfile_pc.sv
// ---------------------------------------------------------------------------
// regfile_pc
// Eight-entry register file with write bypass, pending-write scoreboard and
// the fetch program counter.
//   clk, reset                 : clock, synchronous active-high reset
//   wb_rf_write_en/addr/data   : writeback register write
//   wb_only_high               : write upper byte only (mvhi)
//   wb_pc_enable, wb_pc        : writeback redirect of the PC
//   rd_addr_a/b, rd_data_a/b   : combinational read ports
//   rd_busy_a/b                : read register has a write in flight
//   issue_valid, issue_addr    : decode issued a writer of issue_addr
//   fetch_stall                : hold the PC
//   pc                         : current fetch address
//   flush                      : squash pulse, cycle after a redirect
//   sb_error                   : sticky scoreboard overflow
// ---------------------------------------------------------------------------
module regfile_pc
    import cpu_pkg::*;
#(
    parameter logic [REG_W-1:0] RESET_PC = 16'h0000,
    parameter logic [REG_W-1:0] PC_STEP  = 16'd2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               wb_rf_write_en,
    input  logic               wb_only_high,
    input  logic [RADDR_W-1:0] wb_rf_addr,
    input  logic [REG_W-1:0]   wb_rf_data,
    input  logic               wb_pc_enable,
    input  logic [REG_W-1:0]   wb_pc,
    input  logic [RADDR_W-1:0] rd_addr_a,
    input  logic [RADDR_W-1:0] rd_addr_b,
    output logic [REG_W-1:0]   rd_data_a,
    output logic [REG_W-1:0]   rd_data_b,
    output logic               rd_busy_a,
    output logic               rd_busy_b,
    input  logic               issue_valid,
    input  logic [RADDR_W-1:0] issue_addr,
    input  logic               fetch_stall,
    output logic [REG_W-1:0]   pc,
    output logic               flush,
    output logic               sb_error
);

    word_t regs [NREG];
    word_t wb_value;

    // Value the destination register will hold after this cycle's write;
    // shared by the register update and the read bypass.
    assign wb_value = wb_only_high ? merge_high(wb_rf_data, regs[wb_rf_addr])
                                   : wb_rf_data;

    // Register array; writes still happen on redirect cycles (call link)
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (wb_rf_write_en) begin
            regs[wb_rf_addr] <= wb_value;
        end
    end

    assign rd_data_a = (wb_rf_write_en && (wb_rf_addr == rd_addr_a)) ? wb_value : regs[rd_addr_a];
    assign rd_data_b = (wb_rf_write_en && (wb_rf_addr == rd_addr_b)) ? wb_value : regs[rd_addr_b];

    // PC: redirect beats stall, sequential fetch wraps at 2^16
    always_ff @(posedge clk) begin
        if (reset) begin
            pc    <= RESET_PC;
            flush <= 1'b0;
        end else begin
            flush <= wb_pc_enable;
            if (wb_pc_enable) begin
                pc <= wb_pc;
            end else if (!fetch_stall) begin
                pc <= pc + PC_STEP;
            end
        end
    end

    rf_scoreboard u_scoreboard (
        .clk          (clk),
        .reset        (reset),
        .issue_valid  (issue_valid),
        .issue_addr   (issue_addr),
        .retire_valid (wb_rf_write_en),
        .retire_addr  (wb_rf_addr),
        .squash       (wb_pc_enable),
        .rd_addr_a    (rd_addr_a),
        .rd_addr_b    (rd_addr_b),
        .rd_busy_a    (rd_busy_a),
        .rd_busy_b    (rd_busy_b),
        .sb_error     (sb_error)
    );

endmodule

// File: tb/tb_regfile_pc.sv
// ---------------------------------------------------------------------------
// tb_regfile_pc
// Directed scenarios with literal expectations followed by random traffic,
// all compared every cycle against a behavioural model of the register
// file, pending-write counts and PC.
// ---------------------------------------------------------------------------
module tb_regfile_pc;

    localparam logic [15:0] TB_RESET_PC = 16'h0100;
    localparam logic [15:0] TB_PC_STEP  = 16'd2;

    logic        clk = 1'b0;
    logic        reset;
    logic        wb_rf_write_en;
    logic        wb_only_high;
    logic [2:0]  wb_rf_addr;
    logic [15:0] wb_rf_data;
    logic        wb_pc_enable;
    logic [15:0] wb_pc;
    logic [2:0]  rd_addr_a;
    logic [2:0]  rd_addr_b;
    logic [15:0] rd_data_a;
    logic [15:0] rd_data_b;
    logic        rd_busy_a;
    logic        rd_busy_b;
    logic        issue_valid;
    logic [2:0]  issue_addr;
    logic        fetch_stall;
    logic [15:0] pc;
    logic        flush;
    logic        sb_error;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic        rst;
        logic        we;
        logic        oh;
        logic [2:0]  waddr;
        logic [15:0] wdata;
        logic        pce;
        logic [15:0] wpc;
        logic [2:0]  ra;
        logic [2:0]  rb;
        logic        iv;
        logic [2:0]  ia;
        logic        stall;
    } stim_t;

    stim_t s;

    // Behavioural model state
    logic [15:0] m_reg [8];
    int          m_cnt [8];
    logic [15:0] m_pc;
    logic        m_flush;
    logic        m_err;

    always #5 clk = ~clk;

    regfile_pc #(
        .RESET_PC (TB_RESET_PC),
        .PC_STEP  (TB_PC_STEP)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .wb_rf_write_en (wb_rf_write_en),
        .wb_only_high   (wb_only_high),
        .wb_rf_addr     (wb_rf_addr),
        .wb_rf_data     (wb_rf_data),
        .wb_pc_enable   (wb_pc_enable),
        .wb_pc          (wb_pc),
        .rd_addr_a      (rd_addr_a),
        .rd_addr_b      (rd_addr_b),
        .rd_data_a      (rd_data_a),
        .rd_data_b      (rd_data_b),
        .rd_busy_a      (rd_busy_a),
        .rd_busy_b      (rd_busy_b),
        .issue_valid    (issue_valid),
        .issue_addr     (issue_addr),
        .fetch_stall    (fetch_stall),
        .pc             (pc),
        .flush          (flush),
        .sb_error       (sb_error)
    );

    task automatic compare(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic stim_t idleStim();
        stim_t t;
        t = '0;
        return t;
    endfunction

    function automatic stim_t randomStim();
        stim_t t;
        t.rst   = ($urandom_range(0, 299) == 0);
        t.we    = ($urandom_range(0, 1) == 1);
        t.oh    = ($urandom_range(0, 3) == 0);
        t.waddr = 3'($urandom_range(0, 7));
        t.wdata = 16'($urandom);
        t.pce   = ($urandom_range(0, 15) == 0);
        t.wpc   = 16'($urandom);
        t.ra    = 3'($urandom_range(0, 7));
        t.rb    = 3'($urandom_range(0, 7));
        t.iv    = ($urandom_range(0, 2) != 0);
        t.ia    = 3'($urandom_range(0, 7));
        t.stall = ($urandom_range(0, 3) == 0);
        return t;
    endfunction

    task automatic applyStimulus(input stim_t t);
        reset          = t.rst;
        wb_rf_write_en = t.we;
        wb_only_high   = t.oh;
        wb_rf_addr     = t.waddr;
        wb_rf_data     = t.wdata;
        wb_pc_enable   = t.pce;
        wb_pc          = t.wpc;
        rd_addr_a      = t.ra;
        rd_addr_b      = t.rb;
        issue_valid    = t.iv;
        issue_addr     = t.ia;
        fetch_stall    = t.stall;
    endtask

    // What a read of register a returns right now, including this cycle's write
    function automatic logic [15:0] expRead(input logic [2:0] a);
        if (wb_rf_write_en && wb_rf_addr == a) begin
            if (wb_only_high) return {wb_rf_data[15:8], m_reg[a][7:0]};
            return wb_rf_data;
        end
        return m_reg[a];
    endfunction

    // Pending writes left once this cycle's retire is taken away
    function automatic logic expBusy(input logic [2:0] a);
        int left;
        left = m_cnt[a] - ((wb_rf_write_en && wb_rf_addr == a) ? 1 : 0);
        return left > 0;
    endfunction

    task automatic checkOutput();
        compare("rd_data_a", rd_data_a, expRead(rd_addr_a));
        compare("rd_data_b", rd_data_b, expRead(rd_addr_b));
        compare("rd_busy_a", 16'(rd_busy_a), 16'(expBusy(rd_addr_a)));
        compare("rd_busy_b", 16'(rd_busy_b), 16'(expBusy(rd_addr_b)));
        compare("pc", pc, m_pc);
        compare("flush", 16'(flush), 16'(m_flush));
        compare("sb_error", 16'(sb_error), 16'(m_err));
    endtask

    task automatic modelReset();
        for (int i = 0; i < 8; i++) begin
            m_reg[i] = 16'h0000;
            m_cnt[i] = 0;
        end
        m_pc    = TB_RESET_PC;
        m_flush = 1'b0;
        m_err   = 1'b0;
    endtask

    // Advance the model by one clock using the inputs currently driven
    task automatic modelUpdate();
        logic [15:0] wval;
        int          delta;
        if (reset) begin
            modelReset();
        end else begin
            wval = expRead(wb_rf_addr);
            if (wb_rf_write_en) m_reg[wb_rf_addr] = wval;
            for (int i = 0; i < 8; i++) begin
                if (wb_pc_enable) begin
                    m_cnt[i] = 0;
                end else begin
                    delta = ((issue_valid && int'(issue_addr) == i) ? 1 : 0)
                          - ((wb_rf_write_en && int'(wb_rf_addr) == i) ? 1 : 0);
                    if (delta == 1 && m_cnt[i] == 3) m_err = 1'b1;
                    else if (delta == 1) m_cnt[i] = m_cnt[i] + 1;
                    else if (delta == -1 && m_cnt[i] > 0) m_cnt[i] = m_cnt[i] - 1;
                end
            end
            m_flush = wb_pc_enable;
            if (wb_pc_enable) m_pc = wb_pc;
            else if (!fetch_stall) m_pc = 16'(m_pc + TB_PC_STEP);
        end
    endtask

    // Check at the falling edge, advance the model, land 1 after the rise
    task automatic step();
        @(negedge clk);
        checkOutput();
        modelUpdate();
        @(posedge clk);
        #1;
    endtask

    initial begin
        s = idleStim();
        s.rst = 1'b1;
        applyStimulus(s);
        @(posedge clk);
        #1;
        modelReset();
        s = idleStim();
        s.ra = 3'd0;
        s.rb = 3'd6;
        applyStimulus(s);
        #1;
        compare("reset_pc", pc, 16'h0100);
        compare("reset_flush", 16'(flush), 16'h0000);
        compare("reset_sb_error", 16'(sb_error), 16'h0000);
        compare("reset_r0", rd_data_a, 16'h0000);
        compare("reset_r6", rd_data_b, 16'h0000);
        step();

        // Full write then high-byte write with same-cycle bypass
        s = idleStim(); s.we = 1'b1; s.waddr = 3'd3; s.wdata = 16'hABCD; s.stall = 1'b1;
        applyStimulus(s); step();
        s = idleStim(); s.we = 1'b1; s.oh = 1'b1; s.waddr = 3'd3; s.wdata = 16'h12FF; s.ra = 3'd3; s.stall = 1'b1;
        applyStimulus(s); #1;
        compare("mvhi_bypass", rd_data_a, 16'h12CD);
        step();
        s = idleStim(); s.ra = 3'd3; s.stall = 1'b1;
        applyStimulus(s); #1;
        compare("mvhi_stored", rd_data_a, 16'h12CD);
        step();

        // Two issues to r5, then two retires
        s = idleStim(); s.iv = 1'b1; s.ia = 3'd5;
        applyStimulus(s); step();
        applyStimulus(s); step();
        s = idleStim(); s.we = 1'b1; s.waddr = 3'd5; s.wdata = 16'h5555; s.rb = 3'd5;
        applyStimulus(s); #1;
        compare("busy_after_one_retire", 16'(rd_busy_b), 16'h0001);
        step();
        applyStimulus(s); #1;
        compare("busy_cleared_on_retire", 16'(rd_busy_b), 16'h0000);
        step();

        // Overflow r2's counter
        s = idleStim(); s.iv = 1'b1; s.ia = 3'd2; s.ra = 3'd2;
        for (int k = 0; k < 3; k++) begin
            applyStimulus(s); step();
        end
        compare("no_error_at_three", 16'(sb_error), 16'h0000);
        applyStimulus(s); step();
        s = idleStim(); s.ra = 3'd2;
        applyStimulus(s); #1;
        compare("error_on_overflow", 16'(sb_error), 16'h0001);
        compare("r2_busy_saturated", 16'(rd_busy_a), 16'h0001);
        step(); step();
        compare("error_sticky", 16'(sb_error), 16'h0001);

        // PC wrap and stall hold
        s = idleStim(); s.pce = 1'b1; s.wpc = 16'hFFFE;
        applyStimulus(s); step();
        compare("pc_redirect_fffe", pc, 16'hFFFE);
        s = idleStim();
        applyStimulus(s); step();
        compare("pc_wrap", pc, 16'h0000);
        s = idleStim(); s.stall = 1'b1;
        applyStimulus(s); step();
        compare("pc_stall_hold", pc, 16'h0000);
        compare("error_survives_redirect", 16'(sb_error), 16'h0001);

        // Redirect with stall, squashed issue, and a call writing r7
        s = idleStim(); s.pce = 1'b1; s.wpc = 16'h0040; s.stall = 1'b1;
        s.iv = 1'b1; s.ia = 3'd1; s.we = 1'b1; s.waddr = 3'd7; s.wdata = 16'h1234;
        applyStimulus(s); step();
        s = idleStim(); s.stall = 1'b1; s.ra = 3'd1; s.rb = 3'd2;
        applyStimulus(s); #1;
        compare("redirect_pc", pc, 16'h0040);
        compare("redirect_flush", 16'(flush), 16'h0001);
        compare("r1_not_pending", 16'(rd_busy_a), 16'h0000);
        compare("r2_cleared", 16'(rd_busy_b), 16'h0000);
        s.rb = 3'd7;
        applyStimulus(s); #1;
        compare("call_write_r7", rd_data_b, 16'h1234);
        step();
        compare("flush_single_pulse", 16'(flush), 16'h0000);

        // Back-to-back redirects
        s = idleStim(); s.pce = 1'b1; s.wpc = 16'h0080;
        applyStimulus(s); step();
        s.wpc = 16'h00C0;
        applyStimulus(s); step();
        compare("b2b_flush", 16'(flush), 16'h0001);
        compare("b2b_pc", pc, 16'h00C0);
        s = idleStim();
        applyStimulus(s); step();
        compare("b2b_flush_end", 16'(flush), 16'h0000);

        // Reset beats same-cycle write, issue and redirect
        s = idleStim(); s.rst = 1'b1; s.we = 1'b1; s.waddr = 3'd3; s.wdata = 16'hFFFF;
        s.pce = 1'b1; s.wpc = 16'h5555; s.iv = 1'b1; s.ia = 3'd4;
        applyStimulus(s); step();
        s = idleStim(); s.ra = 3'd3; s.rb = 3'd4; s.stall = 1'b1;
        applyStimulus(s); #1;
        compare("reset_mid_r3", rd_data_a, 16'h0000);
        compare("reset_mid_r4_idle", 16'(rd_busy_b), 16'h0000);
        compare("reset_mid_pc", pc, 16'h0100);
        compare("reset_mid_flush", 16'(flush), 16'h0000);
        compare("reset_mid_error", 16'(sb_error), 16'h0000);
        step();

        // Random traffic against the model
        for (int n = 0; n < 1500; n++) begin
            applyStimulus(randomStim());
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/regfile_pc.md
REGFILE_PC -- requirements
Module: regfile_pc

Interface
REQ-001 Parameter RESET_PC, default 16'h0000, PC value loaded on reset.
REQ-002 Parameter PC_STEP, default 16'd2, sequential fetch increment.
REQ-003 Clock is clk; reset is reset, synchronous, active-high; one clock domain.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 reset  in  1  synchronous active-high reset.
REQ-006 wb_rf_write_en  in  1  writeback register write strobe.
REQ-007 wb_only_high  in  1  write upper byte only (mvhi).
REQ-008 wb_rf_addr  in  3  writeback destination register.
REQ-009 wb_rf_data  in  16  writeback data.
REQ-010 wb_pc_enable  in  1  writeback PC redirect strobe.
REQ-011 wb_pc  in  16  redirect target.
REQ-012 rd_addr_a / rd_addr_b  in  3 each  read port addresses.
REQ-013 rd_data_a / rd_data_b  out  16 each  read data.
REQ-014 rd_busy_a / rd_busy_b  out  1 each  addressed register has a pending write.
REQ-015 issue_valid  in  1  decode issues an instruction that writes issue_addr.
REQ-016 issue_addr  in  3  destination of issued instruction.
REQ-017 fetch_stall  in  1  hold PC.
REQ-018 pc  out  16  current fetch address.
REQ-019 flush  out  1  one-cycle squash pulse for in-flight instructions.
REQ-020 sb_error  out  1  sticky scoreboard overflow flag.

Function
REQ-021 Eight 16-bit registers r0..r7, all writable, none hardwired.
REQ-022 Full write: reg[wb_rf_addr] <= wb_rf_data when wb_rf_write_en and !wb_only_high.
REQ-023 High write: reg[wb_rf_addr] <= {wb_rf_data[15:8], reg[wb_rf_addr][7:0]} when wb_rf_write_en and wb_only_high.
REQ-024 Reads combinational; same-cycle write to the read address bypasses (merged value for high write), so write-to-read latency is 0 cycles.
REQ-025 Per-register 2-bit pending count: +1 on issue_valid to that register, -1 on wb_rf_write_en to that register; both in one cycle to the same register = no change.
REQ-026 rd_busy_x = (count[rd_addr_x] != 0) excluding the one write retiring this cycle, i.e. busy only if count minus same-cycle retire > 0.
REQ-027 Issue at count 3 (no retire same cycle): count holds at 3, sb_error set until reset.
REQ-028 Retire at count 0: count holds at 0, no error (call/forced writes tolerated).
REQ-029 wb_pc_enable clears all pending counts to 0 next cycle; a same-cycle issue_valid is ignored (squashed).
REQ-030 PC priority: wb_pc_enable -> pc <= wb_pc; else !fetch_stall -> pc <= pc + PC_STEP modulo 2^16; else hold.
REQ-031 flush registered: high exactly the cycle after a wb_pc_enable cycle; back-to-back redirects give back-to-back flush.
REQ-032 Register-file write on a redirect cycle (call writing r7) still performed.

Reset
REQ-033 On reset: all registers 0, all pending counts 0, pc = RESET_PC, flush = 0, sb_error = 0.
REQ-034 Reset overrides all same-cycle writes, issues and redirects; reset mid-stream discards them.

Structure
REQ-035 Shared package cpu_pkg holds REG_W=16, NREG=8, RADDR_W=3, SB_CNT_W=2.
REQ-036 Pending counters and busy/error logic in sub-module rf_scoreboard; registers, bypass and PC in regfile_pc.

Verification
REQ-037 Write r3=16'hABCD, then high write r3 data 16'h12FF -> r3 reads 16'h12CD; same-cycle read shows 16'h12CD.
REQ-038 Issue r5 twice, retire once -> rd_busy=1; retire again -> rd_busy=0 the same cycle as the retire.
REQ-039 Issue r2 four times with no retire -> count 3, sb_error=1 and stays 1 until reset.
REQ-040 pc=16'hFFFE, no stall -> pc=16'h0000 next cycle; fetch_stall=1 holds pc.
REQ-041 wb_pc_enable with wb_pc=16'h0040, fetch_stall=1, issue_valid=1 on r1 -> pc=16'h0040, flush=1 one cycle later, all busy=0, r1 not pending.
REQ-042 Reset asserted with wb_rf_write_en and wb_pc_enable active -> registers 0, pc=RESET_PC, flush=0.
